// File: rtl/gate_sweep_if.sv
// gate_sweep_if: stimulus/result bundle between the sweep checker and the gate library under test.
`default_nettype none

interface gate_sweep_if;
  logic       start;
  logic       A;
  logic       B;
  logic [6:0] Y;
  logic       busy;
  logic       done;
  logic       pass;
  logic [6:0] fail_mask;
  logic [1:0] first_fail_vec;
  logic [7:0] err_count;

  modport master (
    input  start, Y,
    output A, B, busy, done, pass, fail_mask, first_fail_vec, err_count
  );

  modport slave (
    output start, Y,
    input  A, B, busy, done, pass, fail_mask, first_fail_vec, err_count
  );
endinterface

`default_nettype wire

// File: rtl/gate_sweep_checker.sv
// ===========================================================================
// gate_sweep_checker
//   Sweeps {A,B} through 00..11 for PASSES sweeps, samples the seven gate
//   outputs after SETTLE_CYCLES and accumulates fail mask / first vector /
//   saturating error count.  Optional: GATE_SWEEP_STOP_ON_FAIL_EN ends the
//   run at the first mismatching sample.
//   Revision: 1.0
// ===========================================================================
`default_nettype none

module gate_sweep_checker #(
  parameter int SETTLE_CYCLES = 2,
  parameter int PASSES        = 1
) (
  input  wire logic   clk,
  input  wire logic   rst,
  gate_sweep_if.master bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES);
  localparam logic [7:0] PASS_LAST   = 8'(PASSES - 1);

  logic [1:0] state;
  logic [1:0] next_state;
  logic [7:0] settle_cnt;
  logic [7:0] pass_cnt;
  logic [1:0] vec;
  logic [6:0] fail_mask;
  logic [1:0] first_fail_vec;
  logic [7:0] err_count;
  logic       pass;

  logic       a;
  logic       b;
  logic [6:0] golden;
  logic [6:0] mismatch;
  logic       any_mismatch;
  logic       last_sample;
  logic       stop_now;
  logic       finish;

  assign a = vec[1];
  assign b = vec[0];

  // Bit order: XNOR, XOR, NOR, NAND, NOT(A), OR, AND
  assign golden       = {~(a ^ b), a ^ b, ~(a | b), ~(a & b), ~a, a | b, a & b};
  assign mismatch     = bus.Y ^ golden;
  assign any_mismatch = |mismatch;
  assign last_sample  = (vec == 2'b11) && (pass_cnt == PASS_LAST);

`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
  assign stop_now = any_mismatch;
`else
  assign stop_now = 1'b0;
`endif

  assign finish = last_sample || stop_now;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (bus.start) next_state = S_SETTLE;
      // A zero or one-cycle settle both collapse to a single SETTLE cycle
      S_SETTLE: if (settle_cnt <= 8'd1) next_state = S_SAMPLE;
      S_SAMPLE: next_state = finish ? S_DONE : S_SETTLE;
      S_DONE:   next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state == S_SETTLE) || (state == S_SAMPLE);
    bus.done = (state == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      settle_cnt     <= 8'd0;
      pass_cnt       <= 8'd0;
      vec            <= 2'b00;
      fail_mask      <= 7'd0;
      first_fail_vec <= 2'b00;
      err_count      <= 8'd0;
      pass           <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            vec            <= 2'b00;
            settle_cnt     <= SETTLE_LOAD;
            pass_cnt       <= 8'd0;
            fail_mask      <= 7'd0;
            first_fail_vec <= 2'b00;
            err_count      <= 8'd0;
            pass           <= 1'b0;
          end
        end
        S_SETTLE: begin
          if (settle_cnt != 8'd0) begin
            settle_cnt <= settle_cnt - 8'd1;
          end
        end
        S_SAMPLE: begin
          fail_mask <= fail_mask | mismatch;
          if (any_mismatch) begin
            if (err_count != 8'hFF) begin
              err_count <= err_count + 8'd1;
            end
            if (fail_mask == 7'd0) begin
              first_fail_vec <= vec;
            end
          end
          if (finish) begin
            pass <= ((fail_mask | mismatch) == 7'd0);
          end else begin
            vec        <= vec + 2'd1;
            settle_cnt <= SETTLE_LOAD;
            if (vec == 2'b11) begin
              pass_cnt <= pass_cnt + 8'd1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.A              = a;
  assign bus.B              = b;
  assign bus.pass           = pass;
  assign bus.fail_mask      = fail_mask;
  assign bus.first_fail_vec = first_fail_vec;
  assign bus.err_count      = err_count;

endmodule

`default_nettype wire

// File: tb/tb_gate_sweep_checker.sv
// tb_gate_sweep_checker: three checker instances with injectable gate faults, a
// cycle-count reference model, directed literal checks and a randomized phase.
`default_nettype none

module tb_gate_sweep_checker;

`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [2:0] start_v;
  logic [6:0] stuck0 [3];
  logic [6:0] stuck1 [3];
  logic [6:0] inv    [3];
  logic [21:0] dut_out [3];

  int n_vec = 0;
  int n_mis = 0;

  // Truth table of the seven gates indexed by {A,B}
  function automatic logic [6:0] gold_of(input logic [1:0] v);
    case (v)
      2'b00:   return 7'h5C;
      2'b01:   return 7'h2E;
      2'b10:   return 7'h2A;
      default: return 7'h43;
    endcase
  endfunction

  function automatic int s_of(input int g);
    return (g == 2) ? 0 : 2;
  endfunction

  function automatic int p_of(input int g);
    return (g == 0) ? 1 : ((g == 1) ? 3 : 2);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    gate_sweep_if bus();
    gate_sweep_checker #(
      .SETTLE_CYCLES(g == 2 ? 0 : 2),
      .PASSES(g == 0 ? 1 : (g == 1 ? 3 : 2))
    ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.master)
    );
    assign bus.start  = start_v[g];
    assign bus.Y      = ((gold_of({bus.A, bus.B}) & ~stuck0[g]) | stuck1[g]) ^ inv[g];
    assign dut_out[g] = {bus.A, bus.B, bus.busy, bus.done, bus.pass,
                         bus.fail_mask, bus.first_fail_vec, bus.err_count};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        run;
    logic        dn;
    logic [15:0] t;
    logic [1:0]  vec;
    logic [6:0]  mask;
    logic [1:0]  first;
    logic [7:0]  err;
    logic        ps;
  } model_t;

  model_t m [3];

  function automatic logic [6:0] fy(input int g, input logic [1:0] v);
    return ((gold_of(v) & ~stuck0[g]) | stuck1[g]) ^ inv[g];
  endfunction

  // Position inside the run is derived from elapsed cycles since start
  function automatic model_t step(input model_t c, input int g, input logic st);
    model_t n;
    int vl, pos, idx;
    logic [6:0] mis;
    n  = c;
    vl = (s_of(g) == 0) ? 2 : s_of(g) + 1;
    if (c.dn) begin
      n.dn = 1'b0;
    end else if (c.run) begin
      pos = (int'(c.t) - 1) % vl;
      idx = (int'(c.t) - 1) / vl;
      if (pos == vl - 1) begin
        mis = fy(g, c.vec) ^ gold_of(c.vec);
        if (mis != 7'd0) begin
          if (c.mask == 7'd0) n.first = c.vec;
          n.err = (c.err == 8'd255) ? 8'd255 : c.err + 8'd1;
        end
        n.mask = c.mask | mis;
        if (idx == 4 * p_of(g) - 1 || (STOP && mis != 7'd0)) begin
          n.run = 1'b0;
          n.dn  = 1'b1;
          n.ps  = (n.mask == 7'd0);
        end else begin
          n.vec = c.vec + 2'd1;
        end
      end
      n.t = c.t + 16'd1;
    end else if (st) begin
      n     = '0;
      n.run = 1'b1;
      n.t   = 16'd1;
    end
    return n;
  endfunction

  function automatic logic [21:0] exp_of(input model_t c);
    return {c.vec, c.run, c.dn, c.ps, c.mask, c.first, c.err};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int g = 0; g < 3; g++) m[g] <= '0;
    end else begin
      for (int g = 0; g < 3; g++) m[g] <= step(m[g], g, start_v[g]);
    end
  end

  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      n_vec++;
      if (dut_out[g] !== exp_of(m[g])) begin
        n_mis++;
        $display("FAIL cycle_check inst%0d t=%0t: got %h expected %h", g, $time, dut_out[g], exp_of(m[g]));
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_fault(input int g, input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] iv);
    stuck0[g] = s0;
    stuck1[g] = s1;
    inv[g]    = iv;
  endtask

  // Called at posedge+2; returns at the negedge where done is seen (cycle count), or -1 after a reset.
  task automatic run_dir(input int g, input bit repulse, input bit rst_mid, output int cyc);
    start_v[g] = 1'b1;
    @(posedge clk);
    #2 start_v[g] = 1'b0;
    cyc = 0;
    while (1) begin
      @(negedge clk);
      cyc++;
      start_v[g] = (repulse && cyc == 5);
      if (rst_mid && cyc == 6) begin
        #1 rst = 1'b1;
        #1 chk("rst_mid_outputs", 32'(dut_out[g]), 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        cyc = -1;
        break;
      end
      if (dut_out[g][18]) break;
      if (cyc > 500) begin
        chk("done_timeout", 32'(cyc), 32'd0);
        break;
      end
    end
    start_v[g] = 1'b0;
  endtask

  task automatic finish_run(input string name, input int g, input int cyc, input int e_cyc,
                            input bit e_pass, input logic [6:0] e_mask, input logic [1:0] e_first,
                            input logic [7:0] e_err);
    chk({name, "_done_cycle"}, 32'(cyc), 32'(e_cyc));
    chk({name, "_pass"}, 32'(dut_out[g][17]), 32'(e_pass));
    chk({name, "_fail_mask"}, 32'(dut_out[g][16:10]), 32'(e_mask));
    chk({name, "_first_fail_vec"}, 32'(dut_out[g][9:8]), 32'(e_first));
    chk({name, "_err_count"}, 32'(dut_out[g][7:0]), 32'(e_err));
    @(posedge clk);
    #2;
  endtask

  initial begin
    int c;
    int extra;
    rst     = 1'b1;
    start_v = 3'b000;
    for (int g = 0; g < 3; g++) set_fault(g, 7'h00, 7'h00, 7'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    for (int g = 0; g < 3; g++) chk("reset_outputs", 32'(dut_out[g]), 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;

    run_dir(0, 1'b0, 1'b0, c);
    finish_run("clean_defaults", 0, c, 13, 1'b1, 7'h00, 2'b00, 8'd0);

    set_fault(0, 7'h20, 7'h00, 7'h00);
    run_dir(0, 1'b0, 1'b0, c);
    if (STOP) finish_run("xor_stuck0", 0, c, 7, 1'b0, 7'h20, 2'b01, 8'd1);
    else      finish_run("xor_stuck0", 0, c, 13, 1'b0, 7'h20, 2'b01, 8'd2);
    set_fault(0, 7'h00, 7'h00, 7'h00);

    set_fault(1, 7'h00, 7'h01, 7'h00);
    run_dir(1, 1'b0, 1'b0, c);
    if (STOP) finish_run("and_stuck1_p3", 1, c, 4, 1'b0, 7'h01, 2'b00, 8'd1);
    else      finish_run("and_stuck1_p3", 1, c, 37, 1'b0, 7'h01, 2'b00, 8'd9);
    set_fault(1, 7'h00, 7'h00, 7'h00);

    run_dir(0, 1'b1, 1'b0, c);
    finish_run("restart_ignored", 0, c, 13, 1'b1, 7'h00, 2'b00, 8'd0);
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (dut_out[0][18]) extra++;
    end
    chk("restart_extra_done", 32'(extra), 32'd0);
    @(posedge clk);
    #2;

    run_dir(0, 1'b0, 1'b1, c);
    chk("rst_mid_abort", 32'(c), 32'hFFFF_FFFF);
    run_dir(0, 1'b0, 1'b0, c);
    finish_run("after_rst", 0, c, 13, 1'b1, 7'h00, 2'b00, 8'd0);

    set_fault(0, 7'h00, 7'h00, 7'h40);
    run_dir(0, 1'b0, 1'b0, c);
    if (STOP) finish_run("xnor_inv", 0, c, 4, 1'b0, 7'h40, 2'b00, 8'd1);
    else      finish_run("xnor_inv", 0, c, 13, 1'b0, 7'h40, 2'b00, 8'd4);
    set_fault(0, 7'h00, 7'h00, 7'h00);

    run_dir(2, 1'b0, 1'b0, c);
    finish_run("settle0_p2", 2, c, 17, 1'b1, 7'h00, 2'b00, 8'd0);

    repeat (4000) begin
      @(posedge clk);
      #2;
      rst = ($urandom_range(0, 399) == 0);
      for (int g = 0; g < 3; g++) begin
        if (!m[g].run && $urandom_range(0, 3) == 0) begin
          case ($urandom_range(0, 3))
            0:       set_fault(g, 7'h00, 7'h00, 7'h00);
            1:       set_fault(g, 7'(1 << $urandom_range(0, 6)), 7'h00, 7'h00);
            2:       set_fault(g, 7'h00, 7'(1 << $urandom_range(0, 6)), 7'h00);
            default: set_fault(g, 7'h00, 7'h00, 7'($urandom & $urandom & 32'h7F));
          endcase
        end
        start_v[g] = ($urandom_range(0, 2) == 0);
      end
    end
    rst     = 1'b0;
    start_v = 3'b000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

`default_nettype wire
